// File: rtl/ni_arbiter_if.sv
// ni_arbiter_if
// One native-interface (NI) link: a write channel (request pulse, address,
// data, acknowledge pulse) and a read channel (request pulse, address,
// returned data, valid pulse).
//
// Modports:
//   master - issues requests (WREQ/WADDR/WDATA, RREQ/RADDR) and receives
//            WACK, RDATA and RVALID
//   slave  - receives requests and returns WACK, RDATA and RVALID
//
// Parameters: ADDR_WIDTH, DATA_WIDTH
interface ni_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  WREQ;
  logic [ADDR_WIDTH-1:0] WADDR;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WACK;
  logic                  RREQ;
  logic [ADDR_WIDTH-1:0] RADDR;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RVALID;

  modport master (
    output WREQ, WADDR, WDATA, RREQ, RADDR,
    input  WACK, RDATA, RVALID
  );

  modport slave (
    input  WREQ, WADDR, WDATA, RREQ, RADDR,
    output WACK, RDATA, RVALID
  );
endinterface

// File: rtl/ni_arbiter.sv
// ni_arbiter
// Shares one downstream NI register map between two NI masters. Each
// upstream port has a single pending slot. Pending requests are serialised
// onto the downstream link one at a time with round-robin fairness. The
// write acknowledge, or the read data, is routed back to the port that
// issued the request.
//
// Ports:
//   CLK      - clock
//   RST      - asynchronous, active-high reset
//   s0, s1   - upstream NI ports (slave modport)
//   m        - downstream NI port (master modport)
//   OVERRUN  - sticky per-port dropped-request flags; cleared only by RST
//   TIMEOUT  - one-cycle pulse when a transaction is force-completed
//
// Optional feature: define NI_ARB_TIMEOUT_EN to enable the downstream wait
// limit. When the limit is reached, the arbiter force-completes the
// transaction after TIMEOUT_CYCLES cycles in WAIT. A forced read returns
// all ones. Without the macro, WAIT lasts until the downstream responds
// and TIMEOUT is tied to 0.
module ni_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         CLK,
  input  logic         RST,
  ni_arbiter_if.slave  s0,
  ni_arbiter_if.slave  s1,
  ni_arbiter_if.master m,
  output logic [1:0]   OVERRUN,
  output logic         TIMEOUT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state;
  logic [1:0]            slot_valid;
  logic [1:0]            slot_wnr;
  logic [ADDR_WIDTH-1:0] slot_addr [2];
  logic [DATA_WIDTH-1:0] slot_data [2];
  logic                  grant;
  logic                  prio;

  logic                  m_wreq_q;
  logic                  m_rreq_q;
  logic [ADDR_WIDTH-1:0] m_waddr_q;
  logic [ADDR_WIDTH-1:0] m_raddr_q;
  logic [DATA_WIDTH-1:0] m_wdata_q;
  logic [1:0]            wack_q;
  logic [1:0]            rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [1:0]            overrun_q;

  logic [1:0]            req_w;
  logic [1:0]            req_r;
  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic [DATA_WIDTH-1:0] req_data [2];
  logic                  win;
  logic                  gnt_wnr;
  logic                  done_ok;
  logic                  done_to;
  logic                  done;
  logic [1:0]            done_port;
  logic [1:0]            slot_load;
  logic [1:0]            overrun_set;

  assign req_w       = {s1.WREQ, s0.WREQ};
  assign req_r       = {s1.RREQ, s0.RREQ};
  // A write wins over a read issued in the same cycle, so the slot takes
  // the write address when both request pulses are present.
  assign req_addr[0] = s0.WREQ ? s0.WADDR : s0.RADDR;
  assign req_addr[1] = s1.WREQ ? s1.WADDR : s1.RADDR;
  assign req_data[0] = s0.WDATA;
  assign req_data[1] = s1.WDATA;

  // If only one slot is valid, that port wins. If both are valid, the
  // priority pointer decides.
  assign win = (&slot_valid) ? prio : slot_valid[1];

  // Only the response that matches the granted transaction type counts.
  assign gnt_wnr = slot_wnr[grant];
  assign done_ok = (state == WAIT) && (gnt_wnr ? m.WACK : m.RVALID);

`ifdef NI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  // A real acknowledge on the limit cycle takes precedence over the
  // forced completion.
  assign done_to = (state == WAIT) && !done_ok &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign TIMEOUT = timeout_q;

  // The wait counter restarts at 0 every time the FSM enters WAIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= done_to;
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT && !done)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign done_to               = 1'b0;
  assign TIMEOUT               = 1'b0;
`endif

  assign done      = done_ok | done_to;
  assign done_port = {done & grant, done & ~grant};

  // A slot is free when it is empty, or when its transaction completes on
  // this edge. Any other request on a busy slot is dropped. A read that
  // arrives together with a write is always dropped.
  assign slot_load   = (req_w | req_r) & (~slot_valid | done_port);
  assign overrun_set = (req_w & req_r) |
                       ((req_w | req_r) & slot_valid & ~done_port);

  // FSM, pending slots and registered outputs. Completion pulses and
  // request pulses default low, so each lasts exactly one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      slot_valid <= '0;
      slot_wnr   <= '0;
      grant      <= 1'b0;
      prio       <= 1'b0;
      m_wreq_q   <= 1'b0;
      m_rreq_q   <= 1'b0;
      m_waddr_q  <= '0;
      m_raddr_q  <= '0;
      m_wdata_q  <= '0;
      wack_q     <= '0;
      rvalid_q   <= '0;
      overrun_q  <= '0;
      for (int p = 0; p < 2; p++) begin
        slot_addr[p] <= '0;
        slot_data[p] <= '0;
        rdata_q[p]   <= '0;
      end
    end else begin
      m_wreq_q  <= 1'b0;
      m_rreq_q  <= 1'b0;
      wack_q    <= '0;
      rvalid_q  <= '0;
      overrun_q <= overrun_q | overrun_set;

      case (state)
        IDLE: begin
          if (|slot_valid) begin
            grant <= win;
            prio  <= ~win;
            if (slot_wnr[win]) begin
              m_wreq_q  <= 1'b1;
              m_waddr_q <= slot_addr[win];
              m_wdata_q <= slot_data[win];
            end else begin
              m_rreq_q  <= 1'b1;
              m_raddr_q <= slot_addr[win];
            end
            state <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (done) begin
            if (gnt_wnr) begin
              wack_q[grant] <= 1'b1;
            end else begin
              rvalid_q[grant] <= 1'b1;
              rdata_q[grant]  <= done_ok ? m.RDATA : '1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A reload on the completion edge overrides the slot clear.
      for (int p = 0; p < 2; p++) begin
        if (slot_load[p]) begin
          slot_valid[p] <= 1'b1;
          slot_wnr[p]   <= req_w[p];
          slot_addr[p]  <= req_addr[p];
          slot_data[p]  <= req_data[p];
        end else if (done_port[p]) begin
          slot_valid[p] <= 1'b0;
        end
      end
    end
  end

  assign m.WREQ    = m_wreq_q;
  assign m.RREQ    = m_rreq_q;
  assign m.WADDR   = m_waddr_q;
  assign m.RADDR   = m_raddr_q;
  assign m.WDATA   = m_wdata_q;
  assign s0.WACK   = wack_q[0];
  assign s0.RVALID = rvalid_q[0];
  assign s0.RDATA  = rdata_q[0];
  assign s1.WACK   = wack_q[1];
  assign s1.RVALID = rvalid_q[1];
  assign s1.RDATA  = rdata_q[1];
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_ni_arbiter.sv
// tb_ni_arbiter
// Table-driven bench for ni_arbiter. Each table row gives the inputs for one
// clock cycle and the outputs expected after that cycle's rising edge.
// Hand-written sequences cover an asynchronous reset in the middle of a
// transaction. When NI_ARB_TIMEOUT_EN is defined, they also cover the forced
// read completion with TIMEOUT_CYCLES = 8.
module tb_ni_arbiter;

  typedef struct packed {
    logic [1:0] s0_req;     // {WREQ, RREQ}
    logic [7:0] s0_addr;
    logic [7:0] s0_wdata;
    logic [1:0] s1_req;
    logic [7:0] s1_addr;
    logic [7:0] s1_wdata;
    logic [1:0] m_ack;      // {WACK, RVALID}
    logic [7:0] m_rdata;
  } stim_t;

  typedef struct packed {
    logic [1:0] m_req;      // {WREQ, RREQ}
    logic [7:0] m_waddr;
    logic [7:0] m_raddr;
    logic [7:0] m_wdata;
    logic [1:0] s0_ack;     // {WACK, RVALID}
    logic [7:0] s0_rdata;
    logic [1:0] s1_ack;
    logic [7:0] s1_rdata;
    logic [1:0] overrun;
    logic       timeout;
  } resp_t;

  typedef struct packed {
    stim_t stim;
    resp_t exp;
  } vec_t;

  logic       CLK;
  logic       RST;
  logic [1:0] OVERRUN;
  logic       TIMEOUT;
  int         tests;
  int         fails;
  vec_t       vecs[$];

  ni_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) s0_if ();
  ni_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) s1_if ();
  ni_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) m_if ();

  ni_arbiter #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .s0     (s0_if),
    .s1     (s1_if),
    .m      (m_if),
    .OVERRUN(OVERRUN),
    .TIMEOUT(TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic stim_t st(
    input logic [1:0] s0r, input logic [7:0] a0, input logic [7:0] d0,
    input logic [1:0] s1r, input logic [7:0] a1, input logic [7:0] d1,
    input logic [1:0] ma,  input logic [7:0] md);
    stim_t s;
    s = '{s0r, a0, d0, s1r, a1, d1, ma, md};
    return s;
  endfunction

  function automatic resp_t rs(
    input logic [1:0] mreq, input logic [7:0] wa, input logic [7:0] ra,
    input logic [7:0] wd, input logic [1:0] a0, input logic [7:0] r0,
    input logic [1:0] a1, input logic [7:0] r1, input logic [1:0] ov,
    input logic to);
    resp_t r;
    r = '{mreq, wa, ra, wd, a0, r0, a1, r1, ov, to};
    return r;
  endfunction

  function automatic resp_t sample_outputs();
    resp_t r;
    r.m_req    = {m_if.WREQ, m_if.RREQ};
    r.m_waddr  = m_if.WADDR;
    r.m_raddr  = m_if.RADDR;
    r.m_wdata  = m_if.WDATA;
    r.s0_ack   = {s0_if.WACK, s0_if.RVALID};
    r.s0_rdata = s0_if.RDATA;
    r.s1_ack   = {s1_if.WACK, s1_if.RVALID};
    r.s1_rdata = s1_if.RDATA;
    r.overrun  = OVERRUN;
    r.timeout  = TIMEOUT;
    return r;
  endfunction

  task automatic add_vec(input stim_t s, input resp_t e);
    vecs.push_back('{s, e});
  endtask

  task automatic applyStimulus(input stim_t s);
    s0_if.WREQ   = s.s0_req[1];
    s0_if.RREQ   = s.s0_req[0];
    s0_if.WADDR  = s.s0_addr;
    s0_if.RADDR  = s.s0_addr;
    s0_if.WDATA  = s.s0_wdata;
    s1_if.WREQ   = s.s1_req[1];
    s1_if.RREQ   = s.s1_req[0];
    s1_if.WADDR  = s.s1_addr;
    s1_if.RADDR  = s.s1_addr;
    s1_if.WDATA  = s.s1_wdata;
    m_if.WACK    = s.m_ack[1];
    m_if.RVALID  = s.m_ack[0];
    m_if.RDATA   = s.m_rdata;
  endtask

  task automatic checkOutput(input string name, input resp_t e);
    resp_t a;
    a = sample_outputs();
    tests++;
    if (a !== e) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, a, e);
    end
  endtask

  // Inputs are driven at a falling edge. Outputs are checked at the next
  // falling edge.
  task automatic run_vectors(input string tag);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stim);
      @(negedge CLK);
      checkOutput($sformatf("%s_row%0d", tag, i), vecs[i].exp);
    end
    applyStimulus('0);
    vecs.delete();
  endtask

  initial begin
    stim_t idle;
    idle  = '0;
    tests = 0;
    fails = 0;
    applyStimulus(idle);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("reset_state", '0);
    RST = 1'b0;

    // Simultaneous reads after reset: the pointer starts at port 0.
    add_vec(st(2'b01,8'h01,8'h00, 2'b01,8'h02,8'h00, 2'b00,8'h00), rs(2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00, 2'b00,8'h00, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b01,8'h00,8'h01,8'h00, 2'b00,8'h00, 2'b00,8'h00, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h00,8'h01,8'h00, 2'b00,8'h00, 2'b00,8'h00, 2'b00,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b01,8'h11), rs(2'b00,8'h00,8'h01,8'h00, 2'b01,8'h11, 2'b00,8'h00, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b01,8'h00,8'h02,8'h00, 2'b00,8'h11, 2'b00,8'h00, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h00,8'h02,8'h00, 2'b00,8'h11, 2'b00,8'h00, 2'b00,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b01,8'h22), rs(2'b00,8'h00,8'h02,8'h00, 2'b00,8'h11, 2'b01,8'h22, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h00,8'h02,8'h00, 2'b00,8'h11, 2'b00,8'h22, 2'b00,1'b0));
    // S0 write 0x12/0xA5. The downstream acknowledges 3 cycles after M_WREQ.
    add_vec(st(2'b10,8'h12,8'hA5, 2'b00,8'h00,8'h00, 2'b00,8'h00), rs(2'b00,8'h00,8'h02,8'h00, 2'b00,8'h11, 2'b00,8'h22, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b10,8'h12,8'h02,8'hA5, 2'b00,8'h11, 2'b00,8'h22, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h12,8'h02,8'hA5, 2'b00,8'h11, 2'b00,8'h22, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h12,8'h02,8'hA5, 2'b00,8'h11, 2'b00,8'h22, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h12,8'h02,8'hA5, 2'b00,8'h11, 2'b00,8'h22, 2'b00,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b10,8'h00), rs(2'b00,8'h12,8'h02,8'hA5, 2'b10,8'h11, 2'b00,8'h22, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h12,8'h02,8'hA5, 2'b00,8'h11, 2'b00,8'h22, 2'b00,1'b0));
    // Simultaneous reads again. The last grant went to port 0, so S1 is
    // served first. Wrong-type responses and responses outside WAIT are
    // ignored.
    add_vec(st(2'b01,8'h03,8'h00, 2'b01,8'h04,8'h00, 2'b00,8'h00), rs(2'b00,8'h12,8'h02,8'hA5, 2'b00,8'h11, 2'b00,8'h22, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b01,8'h12,8'h04,8'hA5, 2'b00,8'h11, 2'b00,8'h22, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h12,8'h04,8'hA5, 2'b00,8'h11, 2'b00,8'h22, 2'b00,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b01,8'h44), rs(2'b00,8'h12,8'h04,8'hA5, 2'b00,8'h11, 2'b01,8'h44, 2'b00,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b01,8'hEE), rs(2'b01,8'h12,8'h03,8'hA5, 2'b00,8'h11, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b10,8'h00), rs(2'b00,8'h12,8'h03,8'hA5, 2'b00,8'h11, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b10,8'h00), rs(2'b00,8'h12,8'h03,8'hA5, 2'b00,8'h11, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b01,8'h33), rs(2'b00,8'h12,8'h03,8'hA5, 2'b01,8'h33, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h12,8'h03,8'hA5, 2'b00,8'h33, 2'b00,8'h44, 2'b00,1'b0));
    // A new S0 write on the same edge as the S0 completion reloads the slot
    // without setting the overrun flag.
    add_vec(st(2'b10,8'h40,8'h01, 2'b00,8'h00,8'h00, 2'b00,8'h00), rs(2'b00,8'h12,8'h03,8'hA5, 2'b00,8'h33, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b10,8'h40,8'h03,8'h01, 2'b00,8'h33, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h40,8'h03,8'h01, 2'b00,8'h33, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(st(2'b10,8'h41,8'h02, 2'b00,8'h00,8'h00, 2'b10,8'h00), rs(2'b00,8'h40,8'h03,8'h01, 2'b10,8'h33, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b10,8'h41,8'h03,8'h02, 2'b00,8'h33, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h41,8'h03,8'h02, 2'b00,8'h33, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b10,8'h00), rs(2'b00,8'h41,8'h03,8'h02, 2'b10,8'h33, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h41,8'h03,8'h02, 2'b00,8'h33, 2'b00,8'h44, 2'b00,1'b0));
    // A second S1 write while the first is pending is dropped and sets
    // OVERRUN[1].
    add_vec(st(2'b00,8'h00,8'h00, 2'b10,8'h20,8'h5A, 2'b00,8'h00), rs(2'b00,8'h41,8'h03,8'h02, 2'b00,8'h33, 2'b00,8'h44, 2'b00,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b10,8'h21,8'h6B, 2'b00,8'h00), rs(2'b10,8'h20,8'h03,8'h5A, 2'b00,8'h33, 2'b00,8'h44, 2'b10,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h20,8'h03,8'h5A, 2'b00,8'h33, 2'b00,8'h44, 2'b10,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b10,8'h00), rs(2'b00,8'h20,8'h03,8'h5A, 2'b00,8'h33, 2'b10,8'h44, 2'b10,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h20,8'h03,8'h5A, 2'b00,8'h33, 2'b00,8'h44, 2'b10,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h20,8'h03,8'h5A, 2'b00,8'h33, 2'b00,8'h44, 2'b10,1'b0));
    // S0 WREQ and RREQ together: only the write goes downstream, and
    // OVERRUN[0] is set.
    add_vec(st(2'b11,8'h30,8'h77, 2'b00,8'h00,8'h00, 2'b00,8'h00), rs(2'b00,8'h20,8'h03,8'h5A, 2'b00,8'h33, 2'b00,8'h44, 2'b11,1'b0));
    add_vec(idle,                                                  rs(2'b10,8'h30,8'h03,8'h77, 2'b00,8'h33, 2'b00,8'h44, 2'b11,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h30,8'h03,8'h77, 2'b00,8'h33, 2'b00,8'h44, 2'b11,1'b0));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b10,8'h00), rs(2'b00,8'h30,8'h03,8'h77, 2'b10,8'h33, 2'b00,8'h44, 2'b11,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h30,8'h03,8'h77, 2'b00,8'h33, 2'b00,8'h44, 2'b11,1'b0));
    run_vectors("main");

    // Reset while in WAIT. The late acknowledge must produce no completion.
    applyStimulus(st(2'b10,8'h50,8'h60, 2'b00,8'h00,8'h00, 2'b00,8'h00));
    @(negedge CLK);
    applyStimulus(idle);
    @(negedge CLK);
    checkOutput("rst_issue", rs(2'b10,8'h50,8'h03,8'h60, 2'b00,8'h33, 2'b00,8'h44, 2'b11,1'b0));
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checkOutput("rst_async", '0);
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b10,8'h00));
    @(negedge CLK);
    checkOutput("rst_late_ack", '0);
    applyStimulus(idle);
    @(negedge CLK);
    checkOutput("rst_quiet", '0);

`ifdef NI_ARB_TIMEOUT_EN
    // An unanswered read is forced complete 8 cycles after entering WAIT.
    // A late M_RVALID is then ignored.
    add_vec(st(2'b01,8'h05,8'h00, 2'b00,8'h00,8'h00, 2'b00,8'h00), rs(2'b00,8'h00,8'h00,8'h00, 2'b00,8'h00, 2'b00,8'h00, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b01,8'h00,8'h05,8'h00, 2'b00,8'h00, 2'b00,8'h00, 2'b00,1'b0));
    for (int i = 0; i < 8; i++)
      add_vec(idle,                                                rs(2'b00,8'h00,8'h05,8'h00, 2'b00,8'h00, 2'b00,8'h00, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h00,8'h05,8'h00, 2'b01,8'hFF, 2'b00,8'h00, 2'b00,1'b1));
    add_vec(st(2'b00,8'h00,8'h00, 2'b00,8'h00,8'h00, 2'b01,8'h5C), rs(2'b00,8'h00,8'h05,8'h00, 2'b00,8'hFF, 2'b00,8'h00, 2'b00,1'b0));
    add_vec(idle,                                                  rs(2'b00,8'h00,8'h05,8'h00, 2'b00,8'hFF, 2'b00,8'h00, 2'b00,1'b0));
    run_vectors("timeout");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
